mc_datapath_core: RTL and testbench

- Parametrised multi-cycle CPU core: datapath plus its own state sequencer in one block.
- Replaces the loose datapath-plus-external-control arrangement.
- Generalised data width and register-file depth.
- Instruction and data memories sit outside the block and are reached through req/ack handshakes, so memories with wait states are supported.

---
 rtl/mc_datapath_core.sv | 223 ++++++++++++++++++++++
 tb/tb_mc_datapath_core.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_datapath_core.sv
// mc_datapath_core: multi-cycle CPU core, datapath and state sequencer in one block
// Ports:
//   clk, reset (async, active-low), init_pc (PC loaded at reset)
//   imem_req/imem_addr/imem_ack/imem_rdata : instruction fetch handshake
//   dmem_req/dmem_we/dmem_addr/dmem_wdata/dmem_ack/dmem_rdata : data access handshake
//   pc_out, state_out (IF=0 ID=1 EXE=2 MEM=3 WB=4 HALT=5), halted, illegal
// Optional: define MC_PERF_CNT_EN to add perf_cycles / perf_retired counters.
module mc_datapath_core #(
    parameter int WORD_W   = 32,
    parameter int REG_AW   = 5,
    parameter int LINK_REG = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] init_pc,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [WORD_W-1:0] dmem_addr,
    output logic [WORD_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [WORD_W-1:0] dmem_rdata,
    output logic [WORD_W-1:0] pc_out,
    output logic [2:0]        state_out,
    output logic              halted,
    output logic              illegal
`ifdef MC_PERF_CNT_EN
    ,
    output logic [31:0]       perf_cycles,
    output logic [31:0]       perf_retired
`endif
);

    localparam logic [5:0] OP_ADD  = 6'h00;
    localparam logic [5:0] OP_SUB  = 6'h01;
    localparam logic [5:0] OP_ADDI = 6'h02;
    localparam logic [5:0] OP_OR   = 6'h10;
    localparam logic [5:0] OP_AND  = 6'h11;
    localparam logic [5:0] OP_ORI  = 6'h12;
    localparam logic [5:0] OP_SLL  = 6'h18;
    localparam logic [5:0] OP_SLT  = 6'h26;
    localparam logic [5:0] OP_SW   = 6'h30;
    localparam logic [5:0] OP_LW   = 6'h31;
    localparam logic [5:0] OP_BEQ  = 6'h34;
    localparam logic [5:0] OP_J    = 6'h38;
    localparam logic [5:0] OP_JR   = 6'h39;
    localparam logic [5:0] OP_JAL  = 6'h3A;
    localparam logic [5:0] OP_HALT = 6'h3F;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EXE  = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d, a_q, a_d, b_q, b_d, alu_q, alu_d, mdr_q, mdr_d;
    logic [31:0]       ir_q, ir_d;
    logic              illegal_q, illegal_d;
    logic [WORD_W-1:0] rf_q [2**REG_AW];
    logic              rf_we;
    logic [REG_AW-1:0] rf_wa;
    logic [WORD_W-1:0] rf_wd;

    logic [5:0]        op;
    logic [REG_AW-1:0] rs, rt, rd;
    logic [WORD_W-1:0] sext, zext, jmp, alu_res;
    logic              r_type, op_valid;

    assign op       = ir_q[31:26];
    assign rs       = ir_q[21 +: REG_AW];
    assign rt       = ir_q[16 +: REG_AW];
    assign rd       = ir_q[11 +: REG_AW];
    assign sext     = {{(WORD_W-16){ir_q[15]}}, ir_q[15:0]};
    assign zext     = {{(WORD_W-16){1'b0}}, ir_q[15:0]};
    // PC already holds the incremented fetch address when this is used
    assign jmp      = {pc_q[WORD_W-1:28], ir_q[25:0], 2'b00};
    assign r_type   = op inside {OP_ADD, OP_SUB, OP_OR, OP_AND, OP_SLL, OP_SLT};
    assign op_valid = r_type || op inside {OP_ADDI, OP_ORI, OP_SW, OP_LW, OP_BEQ,
                                           OP_J, OP_JR, OP_JAL, OP_HALT};

    always_comb begin
        case (op)
            OP_ADD:                alu_res = a_q + b_q;
            OP_SUB:                alu_res = a_q - b_q;
            OP_OR:                 alu_res = a_q | b_q;
            OP_AND:                alu_res = a_q & b_q;
            OP_ORI:                alu_res = a_q | zext;
            OP_SLL:                alu_res = b_q << ir_q[10:6];
            OP_SLT:                alu_res = WORD_W'($signed(a_q) < $signed(b_q));
            OP_ADDI, OP_SW, OP_LW: alu_res = a_q + sext;
            default:               alu_res = a_q - b_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_d     = alu_q;
        mdr_d     = mdr_q;
        illegal_d = illegal_q;
        rf_we     = 1'b0;
        rf_wa     = r_type ? rd : rt;
        rf_wd     = (op == OP_LW) ? mdr_q : alu_q;
        case (state_q)
            S_IF: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    pc_d    = pc_q + WORD_W'(4);
                    state_d = S_ID;
                end
            end
            S_ID: begin
                a_d       = rf_q[rs];
                b_d       = rf_q[rt];
                illegal_d = !op_valid;
                state_d   = (op_valid && op != OP_HALT) ? S_EXE : S_HALT;
                if (op == OP_J || op == OP_JAL) begin
                    pc_d    = jmp;
                    state_d = S_IF;
                end
                if (op == OP_JR) begin
                    pc_d    = rf_q[rs];
                    state_d = S_IF;
                end
                if (op == OP_JAL) begin
                    rf_we = 1'b1;
                    rf_wa = REG_AW'(LINK_REG);
                    rf_wd = pc_q;
                end
            end
            S_EXE: begin
                alu_d   = alu_res;
                state_d = (op == OP_BEQ) ? S_IF : (op == OP_LW || op == OP_SW) ? S_MEM : S_WB;
                if (op == OP_BEQ && a_q == b_q)
                    pc_d = pc_q + (sext << 2);
            end
            S_MEM: begin
                if (dmem_ack) begin
                    mdr_d   = (op == OP_LW) ? dmem_rdata : mdr_q;
                    state_d = (op == OP_LW) ? S_WB : S_IF;
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                state_d = S_IF;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IF;
            pc_q      <= init_pc;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_q     <= '0;
            mdr_q     <= '0;
            illegal_q <= 1'b0;
            for (int i = 0; i < 2**REG_AW; i++)
                rf_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_q     <= alu_d;
            mdr_q     <= mdr_d;
            illegal_q <= illegal_d;
            if (rf_we && rf_wa != '0)
                rf_q[rf_wa] <= rf_wd;
        end
    end

    // Requests are gated by reset so they drop the instant reset asserts
    assign imem_req   = reset && state_q == S_IF;
    assign imem_addr  = pc_q;
    assign dmem_req   = reset && state_q == S_MEM;
    assign dmem_we    = op == OP_SW;
    assign dmem_addr  = alu_q;
    assign dmem_wdata = b_q;
    assign pc_out     = pc_q;
    assign state_out  = state_q;
    assign halted     = state_q == S_HALT;
    assign illegal    = illegal_q;

`ifdef MC_PERF_CNT_EN
    logic [31:0] perf_cycles_q, perf_cycles_d, perf_retired_q, perf_retired_d;

    always_comb begin
        perf_cycles_d  = perf_cycles_q + {31'd0, state_q != S_HALT};
        perf_retired_d = perf_retired_q + {31'd0,
            (state_d == S_IF && state_q inside {S_ID, S_EXE, S_MEM, S_WB}) ||
            (state_q == S_ID && op == OP_HALT)};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_cycles_q  <= '0;
            perf_retired_q <= '0;
        end else begin
            perf_cycles_q  <= perf_cycles_d;
            perf_retired_q <= perf_retired_d;
        end
    end

    assign perf_cycles  = perf_cycles_q;
    assign perf_retired = perf_retired_q;
`endif

endmodule

// File: tb/tb_mc_datapath_core.sv
// tb_mc_datapath_core: random instruction stream against an ISA-level model with a scoreboard
module tb_mc_datapath_core;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] init_pc = 32'h0;
    logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, halted, illegal;
    logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, pc_out;
    logic [2:0]  state_out;
`ifdef MC_PERF_CNT_EN
    logic [31:0] perf_cycles, perf_retired;
`endif

    always #5 clk = ~clk;

    mc_datapath_core dut (
        .clk(clk), .reset(reset), .init_pc(init_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .pc_out(pc_out), .state_out(state_out), .halted(halted), .illegal(illegal)
`ifdef MC_PERF_CNT_EN
        , .perf_cycles(perf_cycles), .perf_retired(perf_retired)
`endif
    );

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } dacc_t;

    logic [31:0] fetch_q [$];
    int          cyc_q [$];
    dacc_t       dmem_q [$];
    logic [31:0] prog_q [$];
    logic [31:0] r [32];
    logic [31:0] mpc, ld_data, instr_h;
    logic [5:0]  ops [14] = '{6'h00, 6'h01, 6'h02, 6'h10, 6'h11, 6'h12, 6'h18,
                              6'h26, 6'h30, 6'h31, 6'h34, 6'h38, 6'h39, 6'h3A};
    int checks = 0, fails = 0;
    int n_rand = 0, n_issued = 0, n_ret = 0, tot_cyc = 0;
    int iw = 0, dw = 0, dcnt = 0, base = 0, prev_base = 0, prev_dw = 0;
    bit i_act = 0, d_act = 0, first = 1, stop_issue = 0, stop = 0, mem = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] next_instr();
        logic [31:0] ir;
        if (n_issued < n_rand) begin
            ir = $urandom;
            ir[31:26] = ops[$urandom_range(0, 13)];
            if (ir[31:26] == 6'h34 && ir[0])
                ir[20:16] = ir[25:21];
        end else if (prog_q.size() > 0)
            ir = prog_q.pop_front();
        else
            ir = 32'hFC00_0000;
        n_issued++;
        return ir;
    endfunction

    // ISA-level execution of one instruction; queues the expected bus activity
    task automatic exec(input logic [31:0] ir, output int cyc, output bit halt_now);
        logic [31:0] a, b, sx, pc4, npc, val;
        dacc_t       acc;
        int          dst;
        a = r[ir[25:21]];
        b = r[ir[20:16]];
        sx = {{16{ir[15]}}, ir[15:0]};
        pc4 = mpc + 32'd4;
        npc = pc4;
        val = 0;
        dst = -1;
        cyc = 4;
        halt_now = 0;
        n_ret++;
        case (ir[31:26])
            6'h00: begin val = a + b; dst = ir[15:11]; end
            6'h01: begin val = a - b; dst = ir[15:11]; end
            6'h02: begin val = a + sx; dst = ir[20:16]; end
            6'h10: begin val = a | b; dst = ir[15:11]; end
            6'h11: begin val = a & b; dst = ir[15:11]; end
            6'h12: begin val = a | {16'h0, ir[15:0]}; dst = ir[20:16]; end
            6'h18: begin val = b << ir[10:6]; dst = ir[15:11]; end
            6'h26: begin val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; dst = ir[15:11]; end
            6'h30: begin acc = '{1'b1, a + sx, b}; dmem_q.push_back(acc); end
            6'h31: begin
                ld_data = $urandom;
                acc = '{1'b0, a + sx, b};
                dmem_q.push_back(acc);
                val = ld_data;
                dst = ir[20:16];
                cyc = 5;
            end
            6'h34: begin cyc = 3; if (a == b) npc = pc4 + (sx << 2); end
            6'h38: begin cyc = 2; npc = {pc4[31:28], ir[25:0], 2'b00}; end
            6'h39: begin cyc = 2; npc = a; end
            6'h3A: begin cyc = 2; r[31] = pc4; npc = {pc4[31:28], ir[25:0], 2'b00}; end
            6'h3F: begin cyc = 2; halt_now = 1; end
            default: begin cyc = 2; halt_now = 1; n_ret--; end
        endcase
        if (dst > 0)
            r[dst] = val;
        mpc = npc;
        if (!halt_now)
            fetch_q.push_back(npc);
    endtask

    // Memory environment: answers requests after random wait states, injects stray acks
    initial begin
        imem_ack = 0;
        dmem_ack = 0;
        imem_rdata = 0;
        dmem_rdata = 0;
        forever begin
            @(posedge clk);
            #1;
            imem_ack = 0;
            dmem_ack = 0;
            imem_rdata = $urandom;
            dmem_rdata = $urandom;
            if (reset && imem_req && !i_act && !stop_issue) begin
                instr_h = next_instr();
                mem = instr_h[31:26] inside {6'h30, 6'h31};
                exec(instr_h, base, stop);
                iw = $urandom_range(0, 2);
                dw = mem ? $urandom_range(0, 3) : 0;
                cyc_q.push_back(first ? -1 : prev_base + prev_dw + iw);
                tot_cyc += iw + base + dw + (first ? 1 : 0);
                prev_base = base;
                prev_dw = dw;
                first = 0;
                i_act = 1;
                stop_issue = stop;
            end
            if (i_act) begin
                if (iw == 0) begin
                    imem_ack = 1;
                    imem_rdata = instr_h;
                    i_act = 0;
                end else
                    iw--;
            end else if (reset && !imem_req && $urandom_range(0, 3) == 0)
                imem_ack = 1;
            if (reset && dmem_req && !d_act) begin
                d_act = 1;
                dcnt = dw;
            end
            if (d_act) begin
                if (dcnt == 0) begin
                    dmem_ack = 1;
                    dmem_rdata = ld_data;
                    d_act = 0;
                end else
                    dcnt--;
            end else if (reset && !dmem_req && $urandom_range(0, 3) == 0)
                dmem_ack = 1;
        end
    end

    // Monitor: compares every request cycle against the scoreboard queues
    int cyc = 0, last = 0, c;
    always @(negedge clk) begin
        if (reset) begin
            cyc++;
            if (imem_req) begin
                if (fetch_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL imem_unexpected: got req at %h, expected none", imem_addr);
                end else begin
                    chk("imem_addr", imem_addr, fetch_q[0]);
                    chk("pc_out", pc_out, fetch_q[0]);
                    if (imem_ack) begin
                        void'(fetch_q.pop_front());
                        if (cyc_q.size() > 0) begin
                            c = cyc_q.pop_front();
                            if (c >= 0)
                                chk("cycles", cyc - last, c);
                        end
                        last = cyc;
                    end
                end
            end
            if (dmem_req) begin
                if (dmem_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL dmem_unexpected: got req at %h, expected none", dmem_addr);
                end else begin
                    chk("dmem_we", dmem_we, dmem_q[0].we);
                    chk("dmem_addr", dmem_addr, dmem_q[0].addr);
                    chk("dmem_wdata", dmem_wdata, dmem_q[0].data);
                    if (dmem_ack)
                        void'(dmem_q.pop_front());
                end
            end
        end
    end

    task automatic do_reset(input logic [31:0] ipc);
        @(posedge clk);
        #3;
        reset = 0;
        init_pc = ipc;
        imem_ack = 0;
        dmem_ack = 0;
        #1;
        chk("rst_imem_req_drop", imem_req, 0);
        chk("rst_dmem_req_drop", dmem_req, 0);
        for (int i = 0; i < 32; i++)
            r[i] = 0;
        mpc = ipc;
        fetch_q.delete();
        cyc_q.delete();
        dmem_q.delete();
        fetch_q.push_back(ipc);
        first = 1;
        i_act = 0;
        d_act = 0;
        stop_issue = 0;
        n_issued = 0;
        n_ret = 0;
        tot_cyc = 0;
        repeat (2) @(negedge clk);
        chk("rst_pc", pc_out, ipc);
        chk("rst_state", state_out, 0);
        chk("rst_halted", halted, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_imem_req", imem_req, 0);
        chk("rst_dmem_req", dmem_req, 0);
        @(posedge clk);
        #3;
        reset = 1;
    endtask

    task automatic wait_halt();
        for (int i = 0; i < 20000 && !halted; i++)
            @(negedge clk);
        chk("halted", halted, 1);
        repeat (8) @(negedge clk);
        chk("state_halt", state_out, 5);
        chk("fetch_left", fetch_q.size(), 0);
        chk("dmem_left", dmem_q.size(), 0);
    endtask

    initial begin
        n_rand = 100000;
        do_reset(32'h0000_0100);
        repeat (60) @(negedge clk);
        n_rand = 300;
        prog_q = '{32'hFC00_0000};
        do_reset($urandom & 32'hFFFF_FFFC);
        wait_halt();
        chk("illegal_after_halt", illegal, 0);
`ifdef MC_PERF_CNT_EN
        chk("perf_retired", perf_retired, n_ret);
        chk("perf_cycles", perf_cycles, tot_cyc);
`endif
        n_rand = 0;
        prog_q = '{{6'h02, 5'd0, 5'd5, 16'd9},
                   {6'h00, 5'd5, 5'd5, 5'd0, 11'd0},
                   {6'h30, 5'd5, 5'd0, 16'd4},
                   {6'h30, 5'd0, 5'd5, 16'hFFFC},
                   {6'h3E, 26'd0}};
        do_reset(32'h0000_0100);
        wait_halt();
        chk("illegal_set", illegal, 1);
        n_rand = 20;
        prog_q.delete();
        do_reset(32'h0000_0200);
        wait_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
